// File: rtl/vga_frame_mux.sv
// ============================================================================
// Module   : vga_frame_mux
// Purpose  : Frame-synchronous VGA source selector with valid/ready select,
//            switch deferred to the active source's vsync fall, optional
//            black frames after a switch (`VGA_FRAME_MUX_BLANK_EN), and a
//            single registered output stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_frame_mux #(
    parameter int NUM_SRC      = 3,
    parameter int SEL_W        = 2,
    parameter int COLOR_W      = 1,
    parameter int BLANK_FRAMES = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_SRC-1:0]           src_hsync,
    input  logic [NUM_SRC-1:0]           src_vsync,
    input  logic [NUM_SRC*3*COLOR_W-1:0] src_rgb,
    input  logic [SEL_W-1:0]             sel_req,
    input  logic                         sel_valid,
    output logic                         sel_ready,
    output logic                         hsync_out,
    output logic                         vsync_out,
    output logic [COLOR_W-1:0]           r_out,
    output logic [COLOR_W-1:0]           g_out,
    output logic [COLOR_W-1:0]           b_out,
    output logic [SEL_W-1:0]             active_sel,
    output logic                         switching
);

    localparam int             c_rgb_w   = 3 * COLOR_W;
    localparam logic [SEL_W:0] c_num_src = (SEL_W + 1)'(NUM_SRC);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_pending = 2'd1;
`ifdef VGA_FRAME_MUX_BLANK_EN
    localparam logic [1:0] c_blank   = 2'd2;
`endif

    logic [1:0]         r_state;
    logic [SEL_W-1:0]   r_active_sel;
    logic [SEL_W-1:0]   r_pend_sel;
    logic               r_vs_prev;
    logic               r_hsync;
    logic               r_vsync;
    logic [c_rgb_w-1:0] r_rgb;

    logic               w_act_hs;
    logic               w_act_vs;
    logic [c_rgb_w-1:0] w_act_rgb;
    logic               w_pend_vs;
    logic               w_vs_edge;
    logic               w_req_bad;
    logic               w_blank;

    // Source muxes; both selects are always below NUM_SRC
    always_comb begin
        w_act_hs  = src_hsync[0];
        w_act_vs  = src_vsync[0];
        w_act_rgb = src_rgb[c_rgb_w-1:0];
        w_pend_vs = src_vsync[0];
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_active_sel == SEL_W'(i)) begin
                w_act_hs  = src_hsync[i];
                w_act_vs  = src_vsync[i];
                w_act_rgb = src_rgb[i*c_rgb_w +: c_rgb_w];
            end
            if (r_pend_sel == SEL_W'(i)) begin
                w_pend_vs = src_vsync[i];
            end
        end
    end

    assign w_vs_edge = r_vs_prev & ~w_act_vs;
    assign w_req_bad = ({1'b0, sel_req} >= c_num_src) || (sel_req == r_active_sel);

`ifdef VGA_FRAME_MUX_BLANK_EN
    logic [7:0] r_blank_cnt;
    assign w_blank = (r_state == c_blank);
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^8'(BLANK_FRAMES);
    assign w_blank      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_idle;
            r_active_sel <= '0;
            r_pend_sel   <= '0;
            r_vs_prev    <= 1'b1;
`ifdef VGA_FRAME_MUX_BLANK_EN
            r_blank_cnt  <= 8'd0;
`endif
        end else begin
            r_vs_prev <= w_act_vs;
            case (r_state)
                c_idle: begin
                    if (sel_valid && !w_req_bad) begin
                        r_pend_sel <= sel_req;
                        r_state    <= c_pending;
                    end
                end
                c_pending: begin
                    if (w_vs_edge) begin
                        r_active_sel <= r_pend_sel;
                        // Seed from the new source so the switch itself is not seen as an edge
                        r_vs_prev    <= w_pend_vs;
`ifdef VGA_FRAME_MUX_BLANK_EN
                        if (BLANK_FRAMES == 0) begin
                            r_state <= c_idle;
                        end else begin
                            r_blank_cnt <= 8'(BLANK_FRAMES);
                            r_state     <= c_blank;
                        end
`else
                        r_state <= c_idle;
`endif
                    end
                end
`ifdef VGA_FRAME_MUX_BLANK_EN
                c_blank: begin
                    if (w_vs_edge) begin
                        if (r_blank_cnt <= 8'd1) begin
                            r_blank_cnt <= 8'd0;
                            r_state     <= c_idle;
                        end else begin
                            r_blank_cnt <= r_blank_cnt - 8'd1;
                        end
                    end
                end
`endif
                default: r_state <= c_idle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_rgb   <= '0;
        end else begin
            r_hsync <= w_act_hs;
            r_vsync <= w_act_vs;
            r_rgb   <= w_blank ? '0 : w_act_rgb;
        end
    end

    assign sel_ready  = (r_state == c_idle);
    assign switching  = (r_state != c_idle);
    assign active_sel = r_active_sel;
    assign hsync_out  = r_hsync;
    assign vsync_out  = r_vsync;
    assign r_out      = r_rgb[3*COLOR_W-1:2*COLOR_W];
    assign g_out      = r_rgb[2*COLOR_W-1:COLOR_W];
    assign b_out      = r_rgb[COLOR_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_vga_frame_mux.sv
// ============================================================================
// Module   : tb_vga_frame_mux
// Purpose  : Scoreboard bench for vga_frame_mux (3 sources, 1-bit colour).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_frame_mux;

`ifdef VGA_FRAME_MUX_BLANK_EN
    localparam int NB = 2;
`else
    localparam int NB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] src_hsync;
    logic [2:0] src_vsync;
    logic [8:0] src_rgb;
    logic [1:0] sel_req;
    logic       sel_valid;
    logic       sel_ready;
    logic       hsync_out;
    logic       vsync_out;
    logic       r_out;
    logic       g_out;
    logic       b_out;
    logic [1:0] active_sel;
    logic       switching;

    always #5 clk = ~clk;

    vga_frame_mux #(
        .NUM_SRC      (3),
        .SEL_W        (2),
        .COLOR_W      (1),
        .BLANK_FRAMES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_hsync  (src_hsync),
        .src_vsync  (src_vsync),
        .src_rgb    (src_rgb),
        .sel_req    (sel_req),
        .sel_valid  (sel_valid),
        .sel_ready  (sel_ready),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .r_out      (r_out),
        .g_out      (g_out),
        .b_out      (b_out),
        .active_sel (active_sel),
        .switching  (switching)
    );

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic [2:0] rgb;
    } pix_t;

    pix_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic shuffle_src();
        src_hsync = 3'($urandom);
        src_rgb   = 9'($urandom);
    endtask

    // Expected pixel is taken from the source the scenario says should be live
    task automatic step(input int s, input bit black);
        pix_t e;
        e.hs  = src_hsync[s];
        e.vs  = src_vsync[s];
        e.rgb = black ? 3'b000 : src_rgb[s*3 +: 3];
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'(1), 32'(0));
        end else begin
            e = sb.pop_front();
            chk("pix", 32'({hsync_out, vsync_out, r_out, g_out, b_out}), 32'(e));
        end
        @(negedge clk);
    endtask

    task automatic do_switch(input int from, input int to, input bit early);
        sel_req   = 2'(to);
        sel_valid = 1'b1;
        src_vsync[from] = early ? 1'b1 : 1'b0;
        shuffle_src();
        step(from, 1'b0);
        sel_valid = 1'b0;
        src_vsync[from] = 1'b1;
        chk("ready_pending", 32'(sel_ready), 32'(0));
        chk("switching_pending", 32'(switching), 32'(1));
        if (!early) begin
            repeat (3) begin
                shuffle_src();
                step(from, 1'b0);
                chk("sel_pending", 32'(active_sel), 32'(from));
            end
        end
        src_vsync[from] = 1'b0;
        shuffle_src();
        step(from, 1'b0);
        src_vsync[from] = 1'b1;
        chk("sel_switched", 32'(active_sel), 32'(to));
        chk("switching_after_edge", 32'(switching), 32'(NB != 0));
        for (int k = 0; k < NB; k++) begin
            repeat (3) begin
                shuffle_src();
                step(to, 1'b1);
                chk("switching_blank", 32'(switching), 32'(1));
            end
            src_vsync[to] = 1'b0;
            shuffle_src();
            step(to, 1'b1);
            src_vsync[to] = 1'b1;
            chk("switching_blank_edge", 32'(switching), 32'(k < NB - 1));
        end
        chk("ready_done", 32'(sel_ready), 32'(1));
        shuffle_src();
        step(to, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        sel_valid = 1'b0;
        sel_req   = 2'd0;
        src_hsync = 3'b111;
        src_vsync = 3'b111;
        src_rgb   = 9'd0;
        repeat (2) @(negedge clk);
        chk("rst_hsync", 32'(hsync_out), 32'(1));
        chk("rst_vsync", 32'(vsync_out), 32'(1));
        chk("rst_rgb", 32'({r_out, g_out, b_out}), 32'(0));
        chk("rst_sel", 32'(active_sel), 32'(0));
        chk("rst_switching", 32'(switching), 32'(0));
        chk("rst_ready", 32'(sel_ready), 32'(1));

        rst_n   = 1'b1;
        src_rgb = 9'b000_000_101;
        step(0, 1'b0);
        chk("rgb101", 32'({r_out, g_out, b_out}), 32'(3'b101));
        repeat (4) begin
            shuffle_src();
            step(0, 1'b0);
        end

        // Out-of-range and same-source requests are consumed without effect
        for (int r = 0; r < 2; r++) begin
            sel_req   = (r == 0) ? 2'd3 : 2'd0;
            sel_valid = 1'b1;
            shuffle_src();
            step(0, 1'b0);
            sel_valid = 1'b0;
            chk("discard_ready", 32'(sel_ready), 32'(1));
            chk("discard_sel", 32'(active_sel), 32'(0));
            chk("discard_switching", 32'(switching), 32'(0));
        end

        do_switch(0, 2, 1'b0);
        do_switch(2, 1, 1'b1);

        // Asynchronous reset in the middle of a switch
        sel_req   = 2'd2;
        sel_valid = 1'b1;
        shuffle_src();
        step(1, 1'b0);
        sel_valid = 1'b0;
        src_vsync[1] = 1'b0;
        step(1, 1'b0);
        src_vsync[1] = 1'b1;
        src_hsync    = 3'b000;
        step(2, NB != 0);
        chk("pre_rst_sel", 32'(active_sel), 32'(2));
        rst_n = 1'b0;
        #2;
        chk("arst_sel", 32'(active_sel), 32'(0));
        chk("arst_switching", 32'(switching), 32'(0));
        chk("arst_ready", 32'(sel_ready), 32'(1));
        chk("arst_syncs", 32'({hsync_out, vsync_out}), 32'(2'b11));
        chk("arst_rgb", 32'({r_out, g_out, b_out}), 32'(0));
        @(negedge clk);
        rst_n     = 1'b1;
        src_vsync = 3'b111;
        repeat (3) begin
            shuffle_src();
            step(0, 1'b0);
        end

        chk("sb_drained", 32'(sb.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
